// File: rtl/game_flow_controller.sv
// Game-flow sequencer: start arming, death, respawn, level clear, game over, optional pause; tracks lives and level.
// Latency: one cycle from input to state change; every output is registered and changes together with o_State.
// Backpressure: none; inputs are sampled every cycle, and i_Lane_Hit/i_Level_Up are ignored outside RUNNING.
//
// Ports:
//   i_Clk, i_Rst_L       clock; asynchronous active-low reset
//   i_Switches           debounced switches {4,3,2,1}; all high arms a start, all low leaves GAME_OVER
//   i_Lane_Hit           per-lane collision flags (level)
//   i_Level_Up           one-cycle pulse: the frog reached the goal row
//   i_Pause              pause request, rising-edge sensitive
//   o_State              current state code
//   o_Game_Active/o_Freeze  play enabled / play frozen
//   o_Respawn            one-cycle pulse on the first RUNNING cycle after a start, death or clear
//   o_Lives/o_Level      remaining lives / current level (1-based)
//   o_Hit_Lane           lowest lane index of the last fatal hit
// Build option: define GAME_FLOW_PAUSE_EN to enable the PAUSED state.
//   Without it, i_Pause is ignored and no edge register exists.

module game_flow_controller #(
    parameter int C_NB_LANES     = 4,
    parameter int C_LIVES_INI    = 3,
    parameter int C_MAX_LEVEL    = 9,
    parameter int C_START_HOLD   = 12_500_000,
    parameter int C_DEATH_CYCLES = 25_000_000,
    parameter int C_CLEAR_CYCLES = 25_000_000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic [3:0]            i_Switches,
    input  logic [C_NB_LANES-1:0] i_Lane_Hit,
    input  logic                  i_Level_Up,
    input  logic                  i_Pause,
    output logic [2:0]            o_State,
    output logic                  o_Game_Active,
    output logic                  o_Freeze,
    output logic                  o_Respawn,
    output logic [3:0]            o_Lives,
    output logic [3:0]            o_Level,
    output logic [2:0]            o_Hit_Lane
);

    localparam int C_MAX_A   = (C_START_HOLD > C_DEATH_CYCLES) ? C_START_HOLD : C_DEATH_CYCLES;
    localparam int C_MAX_CYC = (C_MAX_A > C_CLEAR_CYCLES) ? C_MAX_A : C_CLEAR_CYCLES;
    localparam int C_CNT_W   = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ARMING      = 3'd1,
        ST_RUNNING     = 3'd2,
        ST_DYING       = 3'd3,
        ST_LEVEL_CLEAR = 3'd4,
        ST_GAME_OVER   = 3'd5,
        ST_PAUSED      = 3'd6
    } t_state;

    t_state               r_State;
    t_state               w_State_Next;
    logic [C_CNT_W-1:0]   r_Count;
    logic [C_CNT_W-1:0]   w_Count_Next;
    logic [3:0]           r_Lives;
    logic [3:0]           w_Lives_Next;
    logic [3:0]           r_Level;
    logic [3:0]           w_Level_Next;
    logic [2:0]           r_Hit_Lane;
    logic [2:0]           w_Hit_Lane_Next;
    logic [2:0]           w_Hit_Idx;
    logic                 r_Respawn;
    logic                 w_Respawn_Next;
    logic                 r_Game_Active;
    logic                 r_Freeze;
    logic                 r_Run_En;
    logic                 w_Pause_Edge;

`ifdef GAME_FLOW_PAUSE_EN
    logic r_Pause_Q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) r_Pause_Q <= 1'b0;
        else          r_Pause_Q <= i_Pause;
    end

    assign w_Pause_Edge = i_Pause & ~r_Pause_Q;
`else
    logic w_unused_pause;
    assign w_unused_pause = i_Pause;
    assign w_Pause_Edge   = 1'b0;
`endif

    // Lowest set lane wins: scan from the top so the last match is the smallest index.
    always_comb begin
        w_Hit_Idx = 3'd0;
        for (int i = C_NB_LANES - 1; i >= 0; i--) begin
            if (i_Lane_Hit[i]) w_Hit_Idx = 3'(i);
        end
    end

    always_comb begin
        w_State_Next    = r_State;
        w_Lives_Next    = r_Lives;
        w_Level_Next    = r_Level;
        w_Hit_Lane_Next = r_Hit_Lane;
        w_Respawn_Next  = 1'b0;
        w_Count_Next    = (r_Count != '0) ? r_Count - 1'b1 : '0;

        // r_Run_En holds the machine for the first edge after reset release.
        if (r_Run_En) begin
            case (r_State)
                ST_IDLE: begin
                    if (i_Switches == 4'hF) w_State_Next = ST_ARMING;
                end
                ST_ARMING: begin
                    if (i_Switches != 4'hF) begin
                        w_State_Next = ST_IDLE;
                    end else if (r_Count == '0) begin
                        w_Lives_Next   = 4'(C_LIVES_INI);
                        w_Level_Next   = 4'd1;
                        w_Respawn_Next = 1'b1;
                        w_State_Next   = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (|i_Lane_Hit) begin
                        w_Hit_Lane_Next = w_Hit_Idx;
                        if (r_Lives != 4'd0) w_Lives_Next = r_Lives - 4'd1;
                        w_State_Next    = ST_DYING;
                    end else if (w_Pause_Edge) begin
                        w_State_Next = ST_PAUSED;
                    end else if (i_Level_Up) begin
                        if (r_Level < 4'(C_MAX_LEVEL)) w_Level_Next = r_Level + 4'd1;
                        w_State_Next = ST_LEVEL_CLEAR;
                    end
                end
                ST_DYING: begin
                    if (r_Count == '0) begin
                        if (r_Lives == 4'd0) begin
                            w_State_Next = ST_GAME_OVER;
                        end else begin
                            w_Respawn_Next = 1'b1;
                            w_State_Next   = ST_RUNNING;
                        end
                    end
                end
                ST_LEVEL_CLEAR: begin
                    if (r_Count == '0) begin
                        w_Respawn_Next = 1'b1;
                        w_State_Next   = ST_RUNNING;
                    end
                end
                ST_GAME_OVER: begin
                    if (i_Switches == 4'h0) w_State_Next = ST_IDLE;
                end
`ifdef GAME_FLOW_PAUSE_EN
                ST_PAUSED: begin
                    if (w_Pause_Edge) w_State_Next = ST_RUNNING;
                end
`endif
                default: w_State_Next = ST_IDLE;
            endcase

            // Timed states count down from duration-1 so they last exactly that many cycles.
            if (w_State_Next != r_State) begin
                case (w_State_Next)
                    ST_ARMING:      w_Count_Next = C_CNT_W'(C_START_HOLD - 1);
                    ST_DYING:       w_Count_Next = C_CNT_W'(C_DEATH_CYCLES - 1);
                    ST_LEVEL_CLEAR: w_Count_Next = C_CNT_W'(C_CLEAR_CYCLES - 1);
                    default:        w_Count_Next = '0;
                endcase
            end
        end else begin
            w_Count_Next = r_Count;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State       <= ST_IDLE;
            r_Count       <= '0;
            r_Lives       <= 4'(C_LIVES_INI);
            r_Level       <= 4'd1;
            r_Hit_Lane    <= 3'd0;
            r_Respawn     <= 1'b0;
            r_Game_Active <= 1'b0;
            r_Freeze      <= 1'b1;
            r_Run_En      <= 1'b0;
        end else begin
            r_State       <= w_State_Next;
            r_Count       <= w_Count_Next;
            r_Lives       <= w_Lives_Next;
            r_Level       <= w_Level_Next;
            r_Hit_Lane    <= w_Hit_Lane_Next;
            r_Respawn     <= w_Respawn_Next;
            r_Game_Active <= (w_State_Next == ST_RUNNING);
            r_Freeze      <= (w_State_Next != ST_RUNNING);
            r_Run_En      <= 1'b1;
        end
    end

    assign o_State       = r_State;
    assign o_Game_Active = r_Game_Active;
    assign o_Freeze      = r_Freeze;
    assign o_Respawn     = r_Respawn;
    assign o_Lives       = r_Lives;
    assign o_Level       = r_Level;
    assign o_Hit_Lane    = r_Hit_Lane;

endmodule
